ir_fetch_unit: RTL and testbench

- Instruction-fetch and instruction-register stage of the multicycle CPU, directly upstream of the 16-to-32 sign extender.
- On a controller request it:
  - fetches one 32-bit word from instruction memory over a req/ack handshake;
  - latches the word into the IR;
  - exposes the decoded fields, including Imm_16, which feeds the sign extender.
- The IR holds its value between fetches so the later multicycle states see a stable instruction.

---
 rtl/ir_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_ir_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: instruction fetch and instruction register (IR) stage of the multicycle CPU.
//
// A fetch_start pulse in IDLE issues one word read at the word-aligned pc_in over a
// mem_req/mem_ack handshake. The returned word is latched into the IR. The IR holds its
// value between fetches, so later controller states see a stable instruction. Decoded
// fields are plain slices of the IR; Imm_16 feeds the 16-to-32 sign extender.
//
// Build option:
//   FETCH_TIMEOUT_EN - when defined, a fetch aborts after WAIT_MAX cycles of mem_req with
//                      no mem_ack. The abort raises the sticky fetch_err flag. When
//                      undefined, REQ waits indefinitely and fetch_err is tied to 0.
//
// Parameters:
//   PC_WIDTH    - width of pc_in and mem_addr
//   WAIT_MAX    - number of mem_req cycles before a timeout (FETCH_TIMEOUT_EN only, >= 1)
//
// Ports:
//   clk, rst    - clock; synchronous active-high reset
//   fetch_start - one-cycle fetch request from the controller; pc_in is sampled with it
//   mem_req     - memory read request, held with mem_addr until ack or abort
//   mem_addr    - word-aligned fetch address
//   mem_ack     - memory data valid; mem_rdata carries the instruction word
//   busy        - fetch in progress
//   ir_valid    - one-cycle pulse, coincident with new IR contents
//   fetch_err   - sticky timeout flag
//   inst        - IR contents
//   opcode, rs, rt, rd, shamt, funct, Imm_16, target - decoded IR fields

module ir_fetch_unit #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_start,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic                busy,
    output logic                ir_valid,
    output logic                fetch_err,
    output logic [31:0]         inst,
    output logic [5:0]          opcode,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [5:0]          funct,
    output logic [15:0]         Imm_16,
    output logic [25:0]         target
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [PC_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                busy_q, busy_d;
    logic                ir_valid_q, ir_valid_d;
    logic [31:0]         ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_MAX - 1);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            fetch_err_q, fetch_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        ir_d       = ir_q;
        // ir_valid is a pulse: low unless this edge loads the IR.
        ir_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
`endif

        case (state_q)
            StIdle: begin
                // A stray mem_ack here is ignored; mem_rdata is not sampled.
                if (fetch_start) begin
                    mem_addr_d      = pc_in;
                    mem_addr_d[1:0] = 2'b00;
                    mem_req_d       = 1'b1;
                    busy_d          = 1'b1;
                    state_d         = StReq;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d  = '0;
                    fetch_err_d = 1'b0;
`endif
                end
            end

            StReq: begin
                // fetch_start is ignored while busy, including on the ack edge.
                if (mem_ack) begin
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
`ifdef FETCH_TIMEOUT_EN
                end else if (wait_cnt_q == WaitLast) begin
                    // Timeout: the IR keeps its old value and there is no ir_valid pulse.
                    fetch_err_d = 1'b1;
                    mem_req_d   = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset has priority, so a mem_ack on the reset edge is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_q       <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            ir_valid_q <= ir_valid_d;
            ir_q       <= ir_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign ir_valid = ir_valid_q;

    // Field decode is purely combinational, so fields change only when the IR loads.
    assign inst   = ir_q;
    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign Imm_16 = ir_q[15:0];
    assign target = ir_q[25:0];

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Self-checking bench for ir_fetch_unit.
// The reference model is transaction level: the expected IR, fetch address and error flag.
// Per-cycle expectations follow from the handshake rules: mem_req stays high from the start
// edge until the ack edge, and ir_valid is high only in the cycle after the ack edge.

module tb_ir_fetch_unit;

    localparam int unsigned PW = 32;
    localparam int unsigned WM = 8;

    logic          clk;
    logic          rst;
    logic          fetch_start;
    logic [PW-1:0] pc_in;
    logic          mem_req;
    logic [PW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          ir_valid;
    logic          fetch_err;
    logic [31:0]   inst;
    logic [5:0]    opcode;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [15:0]   Imm_16;
    logic [25:0]   target;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state.
    logic [31:0] model_ir;
    logic [31:0] model_addr;
    logic        model_err;

    ir_fetch_unit #(
        .PC_WIDTH (PW),
        .WAIT_MAX (WM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .ir_valid    (ir_valid),
        .fetch_err   (fetch_err),
        .inst        (inst),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .Imm_16      (Imm_16),
        .target      (target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control outputs plus IR against the model; the address only while it is defined.
    task automatic check_outs(input string tag, input logic exp_req, input logic exp_busy,
                              input logic exp_valid, input logic chk_addr);
        check({tag, ".mem_req"}, {31'b0, mem_req}, {31'b0, exp_req});
        check({tag, ".busy"}, {31'b0, busy}, {31'b0, exp_busy});
        check({tag, ".ir_valid"}, {31'b0, ir_valid}, {31'b0, exp_valid});
        check({tag, ".fetch_err"}, {31'b0, fetch_err}, {31'b0, model_err});
        check({tag, ".inst"}, inst, model_ir);
        if (chk_addr) check({tag, ".mem_addr"}, mem_addr, model_addr);
    endtask

    task automatic check_fields(input string tag, input logic [31:0] w);
        check({tag, ".opcode"}, {26'b0, opcode}, {26'b0, w[31:26]});
        check({tag, ".rs"}, {27'b0, rs}, {27'b0, w[25:21]});
        check({tag, ".rt"}, {27'b0, rt}, {27'b0, w[20:16]});
        check({tag, ".rd"}, {27'b0, rd}, {27'b0, w[15:11]});
        check({tag, ".shamt"}, {27'b0, shamt}, {27'b0, w[10:6]});
        check({tag, ".funct"}, {26'b0, funct}, {26'b0, w[5:0]});
        check({tag, ".imm16"}, {16'b0, Imm_16}, {16'b0, w[15:0]});
        check({tag, ".target"}, {6'b0, target}, {6'b0, w[25:0]});
    endtask

    // One fetch with `waits` no-ack REQ cycles, then an ack carrying `data`.
    // Returns in the ir_valid cycle with fetch_start low.
    task automatic do_fetch(input string tag, input logic [31:0] pc, input logic [31:0] data,
                            input int waits);
        fetch_start = 1'b1;
        pc_in       = pc;
        mem_ack     = 1'b0;
        mem_rdata   = $urandom;
        tick();
        fetch_start = 1'b0;
        model_addr  = pc & 32'hFFFF_FFFC;
        model_err   = 1'b0;
        check_outs({tag, ".start"}, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < waits; i++) begin
            // Stray fetch_start and unacknowledged rdata must have no effect.
            fetch_start = 1'($urandom_range(0, 1));
            pc_in       = $urandom;
            mem_rdata   = $urandom;
            tick();
            check_outs({tag, ".wait"}, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        fetch_start = 1'($urandom_range(0, 1));
        pc_in       = $urandom;
        mem_ack     = 1'b1;
        mem_rdata   = data;
        tick();
        fetch_start = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = $urandom;
        model_ir    = data;
        check_outs({tag, ".ack"}, 1'b0, 1'b0, 1'b1, 1'b0);
        check_fields({tag, ".ack"}, data);
    endtask

    // One IDLE cycle, optionally with a mem_ack that must be ignored.
    task automatic idle_cycle(input string tag, input logic ack);
        mem_ack   = ack;
        mem_rdata = $urandom;
        tick();
        mem_ack   = 1'b0;
        check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        fetch_start = 1'b0;
        pc_in       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        model_ir    = '0;
        model_addr  = '0;
        model_err   = 1'b0;

        // Reset.
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check_fields("reset", 32'h0000_0000);
        rst = 1'b0;
        idle_cycle("reset.idle", 1'b0);

        // addi with ack in the first REQ cycle.
        do_fetch("addi", 32'h0000_0104, 32'h2128_FFFC, 0);
        check("addi.opcode_k", {26'b0, opcode}, 32'h0000_0008);
        check("addi.rs_k", {27'b0, rs}, 32'd9);
        check("addi.rt_k", {27'b0, rt}, 32'd8);
        check("addi.imm_k", {16'b0, Imm_16}, 32'h0000_FFFC);
        // A stray mem_ack in IDLE must not touch the IR.
        idle_cycle("addi.idle_ack", 1'b1);

        // Misaligned PC, three wait cycles.
        do_fetch("add", 32'h0000_0107, 32'h0000_0820, 3);
        check("add.rd_k", {27'b0, rd}, 32'd1);
        check("add.funct_k", {26'b0, funct}, 32'h0000_0020);
        // New fetch started straight from the ir_valid cycle.
        do_fetch("b2b", $urandom, $urandom, $urandom_range(0, 6));
        idle_cycle("b2b.idle", 1'b1);

        // Random transactions.
        for (int n = 0; n < 24; n++) begin
            do_fetch("rnd", $urandom, $urandom, $urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) idle_cycle("rnd.idle", 1'($urandom_range(0, 1)));
        end
        idle_cycle("pre_rst.idle", 1'b0);

        // Reset in REQ on the same edge as mem_ack.
        fetch_start = 1'b1;
        pc_in       = $urandom;
        tick();
        fetch_start = 1'b0;
        model_addr  = pc_in & 32'hFFFF_FFFC;
        check_outs("rstreq.start", 1'b1, 1'b1, 1'b0, 1'b1);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        rst        = 1'b0;
        mem_ack    = 1'b0;
        model_ir   = '0;
        model_addr = '0;
        model_err  = 1'b0;
        check_outs("rstreq.abort", 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle("rstreq.idle", 1'b0);

`ifdef FETCH_TIMEOUT_EN
        // Load a known word, then let a fetch time out.
        do_fetch("to.pre", $urandom, $urandom, 1);
        fetch_start = 1'b1;
        pc_in       = $urandom;
        tick();
        fetch_start = 1'b0;
        model_addr  = pc_in & 32'hFFFF_FFFC;
        check_outs("to.req", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < int'(WM); i++) begin
            mem_rdata = $urandom;
            tick();
            check_outs("to.req", 1'b1, 1'b1, 1'b0, 1'b1);
        end
        tick();
        model_err = 1'b1;
        check_outs("to.abort", 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycle("to.sticky", 1'b1);
        // The next fetch clears the flag; its ack lands on the would-be timeout edge.
        do_fetch("to.edge", $urandom, $urandom, int'(WM) - 1);
        idle_cycle("to.after", 1'b0);
`else
        // Without the timeout, a long wait still completes and fetch_err stays low.
        do_fetch("long", $urandom, $urandom, 3 * int'(WM));
        idle_cycle("long.idle", 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
